// File: rtl/operand_capture_pkg.sv
// Shared types for the operand capture front end: FSM encoding and the
// press-to-load arbitration used by the top level.
package operand_capture_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_HAVE_A = 2'd1,
    ST_HAVE_B = 2'd2,
    ST_BOTH   = 2'd3
  } state_e;

  typedef struct packed {
    logic ld_a;
    logic ld_b;
  } load_t;

  // Button 0 (A) wins a same-cycle tie; B's press is dropped, not deferred.
  function automatic load_t arbitrate(input logic [1:0] press);
    load_t l;
    l.ld_a = press[0];
    l.ld_b = press[1] & ~press[0];
    return l;
  endfunction

endpackage

// File: rtl/operand_capture_debounce.sv
// Per-button conditioning: 2-flop synchroniser, stability counter and
// rising-edge detect producing a single-cycle press.
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic          stable, stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      s1       <= raw;
      s2       <= s1;
      stable_d <= stable;
      // Any sample matching the accepted level restarts the stability window.
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = stable & ~stable_d;

endmodule

// File: rtl/operand_capture.sv
// Board-side front end for the equality checker: debounced buttons load
// synchronised switch values into operand registers and track validity.
module operand_capture
  import operand_capture_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] no,
  input  logic             push1,
  input  logic             push2,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             a_valid,
  output logic             b_valid,
  output logic             ready,
  output logic             upd
);

  logic [1:0]       press;
  logic [WIDTH-1:0] no_s1, no_s2;
  load_t            ld;
  state_e           state_q, state_d;

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   ({push2, push1}),
    .press (press)
  );

  assign ld = arbitrate(press);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY:  if (ld.ld_a) state_d = ST_HAVE_A;
                 else if (ld.ld_b) state_d = ST_HAVE_B;
      ST_HAVE_A: if (ld.ld_b) state_d = ST_BOTH;
      ST_HAVE_B: if (ld.ld_a) state_d = ST_BOTH;
      ST_BOTH:   state_d = ST_BOTH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      no_s1   <= '0;
      no_s2   <= '0;
      a       <= '0;
      b       <= '0;
      upd     <= 1'b0;
      state_q <= ST_EMPTY;
    end else begin
      no_s1   <= no;
      no_s2   <= no_s1;
      upd     <= ld.ld_a | ld.ld_b;
      state_q <= state_d;
      if (ld.ld_a) a <= no_s2;
      if (ld.ld_b) b <= no_s2;
    end
  end

  // Validity decodes straight from the state bits (HAVE_A=01, HAVE_B=10, BOTH=11).
  assign a_valid = state_q[0];
  assign b_valid = state_q[1];
  assign ready   = (state_q == ST_BOTH);

endmodule

// File: tb/tb_operand_capture.sv
// Bench for operand_capture with a short debounce window: directed table,
// hand sequences for reset/bounce/switch timing, and a randomized phase
// checked against a sample-history model.
module tb_operand_capture;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] no = '0;
  logic         push1 = 1'b0, push2 = 1'b0;
  logic [W-1:0] a, b;
  logic         a_valid, b_valid, ready, upd;

  int checks = 0;
  int failures = 0;

  operand_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .no(no), .push1(push1), .push2(push2),
    .a(a), .b(b), .a_valid(a_valid), .b_valid(b_valid), .ready(ready), .upd(upd)
  );

  always #5 clk = ~clk;

  // Model: raw input histories since reset; a button level is accepted once
  // its synchronised sample has disagreed with the accepted level for D
  // consecutive edges. Synchronised value at edge k is the raw value of edge k-2.
  bit         hq1[$], hq2[$];
  logic [3:0] hnq[$];
  bit         stb1, stb2, pend1, pend2, mav, mbv, mupd;
  logic [3:0] ma, mb;

  function automatic bit hbit(int btn, int j);
    if (j < 0) return 1'b0;
    return (btn == 0) ? hq1[j] : hq2[j];
  endfunction

  function automatic bit settle(int btn, bit st, int k);
    for (int j = k - D - 1; j <= k - 2; j++)
      if (hbit(btn, j) == st) return st;
    return !st;
  endfunction

  task automatic model_edge();
    int k;
    bit n1, n2;
    logic [3:0] cap;
    if (!rst_n) begin
      hq1.delete(); hq2.delete(); hnq.delete();
      stb1 = 0; stb2 = 0; pend1 = 0; pend2 = 0;
      mav = 0; mbv = 0; mupd = 0; ma = '0; mb = '0;
      return;
    end
    hq1.push_back(push1); hq2.push_back(push2); hnq.push_back(no);
    k = hq1.size() - 1;
    cap = (k >= 2) ? hnq[k-2] : 4'h0;
    mupd = pend1 | pend2;
    if (pend1) begin ma = cap; mav = 1; end
    else if (pend2) begin mb = cap; mbv = 1; end
    n1 = settle(0, stb1, k);
    n2 = settle(1, stb2, k);
    pend1 = n1 & ~stb1;
    pend2 = n2 & ~stb2;
    stb1 = n1; stb2 = n2;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("m_a", 32'(a), 32'(ma));
    chk("m_b", 32'(b), 32'(mb));
    chk("m_a_valid", 32'(a_valid), 32'(mav));
    chk("m_b_valid", 32'(b_valid), 32'(mbv));
    chk("m_ready", 32'(ready), 32'(mav & mbv));
    chk("m_upd", 32'(upd), 32'(mupd));
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0; push1 = 0; push2 = 0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    bit         p1, p2;
    logic [3:0] nv;
    int         cyc;
    logic [3:0] ea, eb;
    bit         eav, ebv, erdy;
    int         eupd;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int ucnt;
    tbl[0]  = '{1, 0, 0, 4'hF, 3,  4'h0, 4'h0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 4'hA, 10, 4'hA, 4'h0, 1, 0, 0, 1};
    tbl[2]  = '{0, 1, 0, 4'hA, 50, 4'hA, 4'h0, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 4'hA, 10, 4'hA, 4'h0, 1, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 4'h3, 10, 4'h3, 4'h0, 1, 0, 0, 1};
    tbl[5]  = '{0, 0, 0, 4'h3, 10, 4'h3, 4'h0, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 4'h3, 10, 4'h3, 4'h3, 1, 1, 1, 1};
    tbl[7]  = '{0, 0, 0, 4'h3, 10, 4'h3, 4'h3, 1, 1, 1, 0};
    tbl[8]  = '{0, 0, 1, 4'h7, 10, 4'h3, 4'h7, 1, 1, 1, 1};
    tbl[9]  = '{0, 0, 0, 4'h7, 10, 4'h3, 4'h7, 1, 1, 1, 0};
    tbl[10] = '{0, 1, 1, 4'hC, 10, 4'hC, 4'h7, 1, 1, 1, 1};
    tbl[11] = '{0, 0, 0, 4'hC, 10, 4'hC, 4'h7, 1, 1, 1, 0};

    // Reset with random inputs, then release while push1 is held.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push1 = 1'($urandom); push2 = 1'($urandom); no = 4'($urandom);
      step();
      chk("rst_outputs", {a, b, a_valid, b_valid, ready, upd}, '0);
    end
    push1 = 1; push2 = 0; no = 4'h6; rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      chk("rel_a_valid", 32'(a_valid), 32'(e == 7));
      chk("rel_upd", 32'(upd), 32'(e == 7));
    end
    chk("rel_a", 32'(a), 32'h6);
    repeat (5) step();

    // Directed table (tbl[0] applies a fresh reset).
    for (int v = 0; v < 12; v++) begin
      rst_n = !tbl[v].rst; push1 = tbl[v].p1; push2 = tbl[v].p2; no = tbl[v].nv;
      ucnt = 0;
      repeat (tbl[v].cyc) begin step(); ucnt += int'(upd); end
      chk($sformatf("tbl%0d_a", v), 32'(a), 32'(tbl[v].ea));
      chk($sformatf("tbl%0d_b", v), 32'(b), 32'(tbl[v].eb));
      chk($sformatf("tbl%0d_av", v), 32'(a_valid), 32'(tbl[v].eav));
      chk($sformatf("tbl%0d_bv", v), 32'(b_valid), 32'(tbl[v].ebv));
      chk($sformatf("tbl%0d_rdy", v), 32'(ready), 32'(tbl[v].erdy));
      chk($sformatf("tbl%0d_upd", v), 32'(ucnt), 32'(tbl[v].eupd));
    end
    rst_n = 1'b1;

    // Bounce on push2: short pulses never accepted, final held level loads once.
    do_reset(2);
    no = 4'h5; ucnt = 0;
    for (int t = 0; t < 4; t++) begin
      push2 = (t % 2 == 0);
      repeat (3) begin step(); ucnt += int'(upd); end
    end
    chk("bounce_no_load", 32'(ucnt + int'(b_valid)), 32'h0);
    push2 = 1;
    for (int e = 1; e <= 7; e++) begin
      step(); ucnt += int'(upd);
      chk("bounce_b_valid", 32'(b_valid), 32'(e == 7));
    end
    chk("bounce_b", 32'(b), 32'h5);
    repeat (10) begin step(); ucnt += int'(upd); end
    chk("bounce_one_load", 32'(ucnt), 32'h1);
    chk("bounce_state", {a_valid, b_valid, ready}, 32'b010);

    // Switch change two cycles before the load edge is captured.
    push2 = 0;
    do_reset(2);
    no = 4'h1; push1 = 1;
    repeat (4) step();
    no = 4'h9;
    repeat (3) step();
    chk("sw_upd", 32'(upd), 32'h1);
    chk("sw_a", 32'(a), 32'h9);
    no = 4'h2;
    repeat (10) step();
    chk("sw_hold_a", 32'(a), 32'h9);

    // Randomized phase against the model, including mid-debounce resets.
    push1 = 0;
    do_reset(2);
    for (int s = 0; s < 300; s++) begin
      push1 = ($urandom_range(0, 2) == 0);
      push2 = ($urandom_range(0, 2) == 0);
      no    = 4'($urandom);
      rst_n = ($urandom_range(0, 39) != 0);
      repeat ($urandom_range(1, 9)) step();
      rst_n = 1'b1;
    end
    repeat (12) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
